// File: rtl/sort_pkg.sv
// Shared constants and types for the parallel sorter and its frame packer.
// Both blocks take N and DW from here so their frame geometry always matches.
package sort_pkg;

  localparam int SORT_N  = 4;
  localparam int SORT_DW = 8;
  localparam logic [SORT_DW-1:0] SORT_PAD = {SORT_DW{1'b1}};
  localparam int SORT_CW = $clog2(SORT_N + 1);

  // FILL: accepting elements into the fill buffer.
  // HOLD: fill buffer is complete but the output register is still occupied.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/sort_frame_packer.sv
// Packs a serial element stream into padded N-element frames for the sorter.
// One fill buffer plus one registered output stage; a full fill buffer waits
// in HOLD while the presented frame is stalled downstream.
//
// Handshakes: a beat or frame moves on a rising edge only when its valid and
// ready are both high in that cycle. The producer keeps valid and its payload
// stable until that happens, and valid never depends on ready. frame_data and
// frame_count are registers, so they stay constant while a frame is offered.
module sort_frame_packer
  import sort_pkg::*;
#(
  parameter int              N   = SORT_N,
  parameter int              DW  = SORT_DW,
  parameter logic [DW-1:0]   PAD = {DW{1'b1}},
  localparam int             CW  = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [DW*N-1:0] frame_data,
  output logic [CW-1:0]   frame_count,
  output logic            frame_valid,
  input  logic            frame_ready,
  output state_t          dbg_state
);

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_idx;
  logic [DW-1:0]         r_fill [N];
  logic [DW-1:0]         w_fill_next [N];
  logic [DW*N-1:0]       w_frame_next;
  logic [DW*N-1:0]       r_frame_data;
  logic [CW-1:0]         r_frame_count;
  logic                  r_frame_valid;
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_out_free;
  logic                  w_load;

  assign in_ready    = (r_state == FILL);
  assign frame_data  = r_frame_data;
  assign frame_count = r_frame_count;
  assign frame_valid = r_frame_valid;
  assign dbg_state   = r_state;

  // Handshake qualification and the single "load output register" decision.
  always_comb begin
    w_accept   = in_valid && in_ready;
    w_complete = w_accept && (in_last || (r_idx == CW'(N - 1)));
    w_out_free = !r_frame_valid || frame_ready;
    w_load     = w_out_free && (w_complete || (r_state == HOLD));
  end

  // Fill buffer as it will look after this edge's beat; the output register
  // loads from this view so the closing beat lands in the frame directly.
  always_comb begin
    w_frame_next = '0;
    for (int k = 0; k < N; k++) begin
      w_fill_next[k] = (w_accept && (r_idx == CW'(k))) ? in_data : r_fill[k];
      w_frame_next[DW*k +: DW] = w_fill_next[k];
    end
  end

  // Next-state logic: park in HOLD only when a frame completes onto a busy output.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL: if (w_complete && !w_out_free) w_state_next = HOLD;
      HOLD: if (w_out_free)                w_state_next = FILL;
      default:                             w_state_next = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_next;
  end

  // Fill buffer and write index; a load re-arms every slot with PAD so short
  // frames come out padded without any per-slot bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      for (int k = 0; k < N; k++) r_fill[k] <= PAD;
    end else if (w_load) begin
      r_idx <= '0;
      for (int k = 0; k < N; k++) r_fill[k] <= PAD;
    end else if (w_accept) begin
      for (int k = 0; k < N; k++) r_fill[k] <= w_fill_next[k];
      // A completed-but-held frame keeps r_idx as its last slot for the count.
      if (!w_complete) r_idx <= r_idx + CW'(1);
    end
  end

  // Output register: load a finished frame, or drop valid after a bare transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_data  <= '0;
      r_frame_count <= '0;
      r_frame_valid <= 1'b0;
    end else if (w_load) begin
      r_frame_data  <= w_frame_next;
      r_frame_count <= r_idx + CW'(1);
      r_frame_valid <= 1'b1;
    end else if (r_frame_valid && frame_ready) begin
      r_frame_valid <= 1'b0;
    end
  end

endmodule

// File: doc/sort_frame_packer.md
Name: sort_frame_packer

Overview:
- Upstream feeder for the N-input combinational parallel sorter.
- Accepts a serial stream of DW-bit elements over a valid/ready handshake and packs up to N elements into one flat DW*N frame.
- Pads short frames and presents each frame on a registered output with its own valid/ready handshake, so the sorter input is stable for the whole time a frame is offered.
- Has one fill buffer plus one output register, so the next frame can start filling while the current frame is stalled downstream.

Parameters:
- N, 4: elements per frame; must equal the sorter's N; N >= 2.
- DW, 8: element width in bits.
- PAD, {DW{1'b1}}: value written into unfilled slots of a short frame.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DW  stream element.
- in_valid  in  1  in_data is valid this cycle.
- in_last  in  1  this element closes the frame early; qualified by in_valid.
- in_ready  out  1  block accepts an element this cycle.
- frame_data  out  DW*N  packed frame; element k sits at bits [DW*(k+1)-1 : DW*k], which is the sorter's input packing.
- frame_count  out  $clog2(N+1)  number of real (non-pad) elements in frame_data, range 1..N.
- frame_valid  out  1  frame_data and frame_count are valid.
- frame_ready  in  1  downstream (sorter consumer) takes the frame.

Behaviour:
- Handshakes: an input beat is accepted when in_valid && in_ready. A frame is transferred out when frame_valid && frame_ready.
- Reset (async, takes effect immediately, regardless of clk):
  - state=FILL, idx=0, in_ready=1.
  - frame_valid=0, frame_data=0, frame_count=0.
  - Fill buffer is loaded with PAD in every slot.
- State FILL (in_ready=1):
  - An accepted beat writes in_data into fill slot idx and increments idx.
  - The frame completes when the beat is accepted with idx==N-1 or with in_last=1. This includes in_last at idx==0, which gives a 1-element frame.
- On frame completion, "output free" means !frame_valid || frame_ready in that cycle.
  - If the output is free: on the same edge, frame_data <= fill buffer (including this beat), frame_count <= idx+1, frame_valid <= 1. Then idx <= 0, fill slots <= PAD, and the state stays FILL. The next element can be accepted the very next cycle.
  - If the output is not free: go to HOLD with the fill buffer and count kept.
- State HOLD (in_ready=0):
  - in_valid, in_data and in_last are ignored.
  - When the output is free: transfer as above (frame_valid stays 1 if it was 1), reset idx and the fill buffer, return to FILL.
  - This costs exactly one in_ready=0 bubble per stalled frame, at minimum.
- frame_valid clears on a transfer when no new frame loads on the same edge.
- frame_data and frame_count hold stable while frame_valid && !frame_ready. They do not change otherwise except on a load.
- Padding: slots idx+1..N-1 of a short frame equal PAD exactly. frame_count excludes pads.
- Latency: the last element accepted at edge t appears on frame_data with frame_valid=1 after edge t. This is one cycle when the output is free.
- Throughput: one element per cycle sustained while frame_ready is held high.
- in_last is ignored when in_valid=0.
- Reset mid-frame discards the partial fill and any held or presented frame.

Decomposition:
- Shared package sort_pkg: default N, DW, PAD; CW = $clog2(N+1); a state enum {FILL, HOLD}.
- Sorter and packer take N and DW from the same package constants.
- No sub-module is required; the fill buffer and output register are plain register arrays inside the block.

Test Plan (N=4, DW=8, PAD=8'hFF):
- Full frame: stream 8'h03,8'h01,8'h04,8'h02 with frame_ready=1 -> one cycle after the 4th beat: frame_data=32'h02040103, frame_count=4, frame_valid=1 for 1 cycle.
- Short frame: 8'h10,8'h20 with in_last on the 2nd beat -> frame_data=32'hFFFF2010, frame_count=2. A single beat 8'h05 with in_last -> frame_data=32'hFFFFFF05, frame_count=1.
- Stall: frame_ready=0; stream 8 elements back-to-back ->
  - 1st frame is presented and held stable.
  - 2nd frame fills, then in_ready=0 (HOLD).
  - Raise frame_ready -> 1st frame leaves, 2nd frame loads the same edge with frame_valid continuously 1, and in_ready returns to 1 the next cycle.
- Streaming: 12 continuous beats 0..11, frame_ready=1 -> in_ready stays 1 throughout; frames 32'h03020100, 32'h07060504, 32'h0B0A0908 appear on consecutive 4-cycle boundaries.
- Reset mid-operation: assert rst after 2 accepted beats while a frame is held -> frame_valid=0, frame_data=0 and in_ready=1 immediately. The next 4 beats 8'hAA,8'hBB,8'hCC,8'hDD yield 32'hDDCCBBAA, count 4.
- Ignored inputs: in_last=1 with in_valid=0, and in_valid=1 during HOLD -> no state change, no element captured.
